// File: rtl/pc_lr_stack.sv
// rtl/pc_lr_stack.sv - program counter with circular link stack and tri-state bus port
// Optional build macro: LR_STACK_OVF_TRAP_EN (drop pushes when full and flag StkErr).
module pc_lr_stack #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic             Clock,
  input  logic             nReset,
  input  logic             PcWe,
  input  logic [1:0]       PcSel,
  input  logic [WIDTH-1:0] AluIn,
  input  logic             LrWe,
  input  logic             LrSel,
  input  logic             PcEn,
  input  logic             LrEn,
  inout  wire  [WIDTH-1:0] SysBus,
  output logic [WIDTH-1:0] Pc,
  output logic             Full,
  output logic             Empty,
  output logic             StkErr
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] pc_q, pc_d;
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    ptr_q, ptr_d, top_idx, wr_idx;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             err_d, wr_en;
  logic             push, pop, is_full, is_empty;
  logic [WIDTH-1:0] top, push_val;

  // ptr_q is the next free slot; the top entry sits just below it
  assign top_idx  = ptr_q - 1'b1;
  assign is_empty = (cnt_q == '0);
  assign is_full  = (cnt_q == CW'(DEPTH));
  assign top      = is_empty ? '0 : mem[top_idx];
  assign push     = LrWe;
  assign pop      = PcWe && (PcSel == 2'b01);
  assign push_val = LrSel ? pc_q : AluIn;

  always_comb begin
    pc_d   = pc_q;
    ptr_d  = ptr_q;
    cnt_d  = cnt_q;
    err_d  = StkErr;
    wr_en  = 1'b0;
    wr_idx = ptr_q;
    if (PcWe) begin
      case (PcSel)
        2'b00:   pc_d = pc_q + 1'b1;
        2'b01:   pc_d = top;
        2'b10:   pc_d = AluIn;
        default: pc_d = pc_q;
      endcase
    end
    if (push && pop) begin
      wr_en = 1'b1;
      if (is_empty) begin
        ptr_d = ptr_q + 1'b1;
        cnt_d = CW'(1);
      end else begin
        wr_idx = top_idx;
      end
    end else if (push) begin
      if (is_full) begin
`ifdef LR_STACK_OVF_TRAP_EN
        err_d = 1'b1;
`else
        // slot at ptr_q holds the oldest entry once the ring is full
        wr_en = 1'b1;
        ptr_d = ptr_q + 1'b1;
`endif
      end else begin
        wr_en = 1'b1;
        ptr_d = ptr_q + 1'b1;
        cnt_d = cnt_q + 1'b1;
      end
    end else if (pop) begin
      if (is_empty) begin
        err_d = 1'b1;
      end else begin
        ptr_d = top_idx;
        cnt_d = cnt_q - 1'b1;
      end
    end
  end

  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      pc_q   <= '0;
      ptr_q  <= '0;
      cnt_q  <= '0;
      StkErr <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      pc_q   <= pc_d;
      ptr_q  <= ptr_d;
      cnt_q  <= cnt_d;
      StkErr <= err_d;
      if (wr_en) mem[wr_idx] <= push_val;
    end
  end

  assign Pc     = pc_q;
  assign Full   = is_full;
  assign Empty  = is_empty;
  assign SysBus = (nReset && PcEn) ? pc_q :
                  (nReset && LrEn) ? top  : 'z;

endmodule

// File: tb/tb_pc_lr_stack.sv
// tb/tb_pc_lr_stack.sv - vector table and scoreboard bench for pc_lr_stack
module tb_pc_lr_stack;

`ifdef LR_STACK_OVF_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif
  localparam logic [15:0] PAT = 16'h5A5A;

  typedef struct {
    logic        pcwe;
    logic [1:0]  pcsel;
    logic [15:0] alu;
    logic        lrwe, lrsel, pcen, lren;
    logic [15:0] e_pc, e_bus;
    logic        e_full, e_empty, e_err;
  } vec_t;

  logic        clk = 1'b0;
  logic        nreset = 1'b0;
  logic        pcwe = 1'b0, lrwe = 1'b0, lrsel = 1'b0, pcen = 1'b0, lren = 1'b0;
  logic [1:0]  pcsel = 2'b00;
  logic [15:0] alu = '0;
  logic        tb_drv = 1'b0;
  wire  [15:0] sysbus;
  logic [15:0] pc;
  logic        full, empty, stkerr;

  int n_checks = 0;
  int n_fail   = 0;
  vec_t tbl[$];
  vec_t exp_q[$];

  assign sysbus = tb_drv ? PAT : 'z;

  always #5 clk = ~clk;

  pc_lr_stack #(.WIDTH(16), .DEPTH(4)) dut (
    .Clock(clk), .nReset(nreset), .PcWe(pcwe), .PcSel(pcsel), .AluIn(alu),
    .LrWe(lrwe), .LrSel(lrsel), .PcEn(pcen), .LrEn(lren), .SysBus(sysbus),
    .Pc(pc), .Full(full), .Empty(empty), .StkErr(stkerr)
  );

  function automatic vec_t mk(logic w, logic [1:0] s, logic [15:0] a, logic lw, logic ls,
                              logic pe, logic le, logic [15:0] epc, logic [15:0] ebus,
                              logic ef, logic ee, logic er);
    vec_t v;
    v.pcwe = w; v.pcsel = s; v.alu = a; v.lrwe = lw; v.lrsel = ls; v.pcen = pe; v.lren = le;
    v.e_pc = epc; v.e_bus = (pe || le) ? ebus : PAT;
    v.e_full = ef; v.e_empty = ee; v.e_err = er;
    return v;
  endfunction

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    pcwe = v.pcwe; pcsel = v.pcsel; alu = v.alu; lrwe = v.lrwe; lrsel = v.lrsel;
    pcen = v.pcen; lren = v.lren; tb_drv = !(v.pcen || v.lren);
  endtask

  task automatic compare(input string tag, input vec_t e);
    check({tag, " pc"}, pc, e.e_pc);
    check({tag, " bus"}, sysbus, e.e_bus);
    check({tag, " full"}, 16'(full), 16'(e.e_full));
    check({tag, " empty"}, 16'(empty), 16'(e.e_empty));
    check({tag, " err"}, 16'(stkerr), 16'(e.e_err));
  endtask

  initial begin
    vec_t v, e;
    // w  sel  alu       lw ls pe le   pc                       bus                      F  E  Err
    tbl.push_back(mk(1, 2'd0, 16'h0000, 0, 0, 1, 0, 16'h0001, 16'h0001, 0, 1, 0));
    tbl.push_back(mk(1, 2'd0, 16'h0000, 0, 0, 1, 0, 16'h0002, 16'h0002, 0, 1, 0));
    tbl.push_back(mk(0, 2'd0, 16'h0000, 0, 0, 1, 0, 16'h0002, 16'h0002, 0, 1, 0));
    tbl.push_back(mk(0, 2'd0, 16'h0000, 1, 1, 0, 1, 16'h0002, 16'h0002, 0, 0, 0));
    tbl.push_back(mk(1, 2'd2, 16'h0100, 0, 0, 0, 1, 16'h0100, 16'h0002, 0, 0, 0));
    tbl.push_back(mk(1, 2'd1, 16'h0000, 0, 0, 1, 0, 16'h0002, 16'h0002, 0, 1, 0));
    tbl.push_back(mk(0, 2'd0, 16'h0011, 1, 0, 0, 1, 16'h0002, 16'h0011, 0, 0, 0));
    tbl.push_back(mk(0, 2'd0, 16'h0022, 1, 0, 0, 1, 16'h0002, 16'h0022, 0, 0, 0));
    tbl.push_back(mk(0, 2'd0, 16'h0033, 1, 0, 0, 1, 16'h0002, 16'h0033, 0, 0, 0));
    tbl.push_back(mk(0, 2'd0, 16'h0044, 1, 0, 0, 1, 16'h0002, 16'h0044, 1, 0, 0));
    tbl.push_back(mk(0, 2'd0, 16'h0055, 1, 0, 0, 1, 16'h0002, TRAP ? 16'h0044 : 16'h0055, 1, 0, TRAP));
    tbl.push_back(mk(1, 2'd1, 16'h0000, 0, 0, 0, 1, TRAP ? 16'h0044 : 16'h0055, TRAP ? 16'h0033 : 16'h0044, 0, 0, TRAP));
    tbl.push_back(mk(1, 2'd1, 16'h0000, 0, 0, 0, 1, TRAP ? 16'h0033 : 16'h0044, TRAP ? 16'h0022 : 16'h0033, 0, 0, TRAP));
    tbl.push_back(mk(1, 2'd1, 16'h0000, 0, 0, 0, 1, TRAP ? 16'h0022 : 16'h0033, TRAP ? 16'h0011 : 16'h0022, 0, 0, TRAP));
    tbl.push_back(mk(1, 2'd1, 16'h0000, 0, 0, 0, 1, TRAP ? 16'h0011 : 16'h0022, 16'h0000, 0, 1, TRAP));
    tbl.push_back(mk(0, 2'd0, 16'h0010, 1, 0, 0, 1, TRAP ? 16'h0011 : 16'h0022, 16'h0010, 0, 0, TRAP));
    tbl.push_back(mk(1, 2'd1, 16'h0020, 1, 0, 0, 1, 16'h0010, 16'h0020, 0, 0, TRAP));
    tbl.push_back(mk(1, 2'd1, 16'h0000, 0, 0, 0, 1, 16'h0020, 16'h0000, 0, 1, TRAP));
    tbl.push_back(mk(1, 2'd1, 16'h0000, 0, 0, 0, 1, 16'h0000, 16'h0000, 0, 1, 1));
    tbl.push_back(mk(1, 2'd1, 16'h0077, 1, 0, 0, 1, 16'h0000, 16'h0077, 0, 0, 1));
    tbl.push_back(mk(1, 2'd2, 16'hFFFF, 0, 0, 1, 1, 16'hFFFF, 16'hFFFF, 0, 0, 1));
    tbl.push_back(mk(0, 2'd2, 16'h0999, 0, 0, 1, 0, 16'hFFFF, 16'hFFFF, 0, 0, 1));
    tbl.push_back(mk(1, 2'd0, 16'h0000, 0, 0, 1, 1, 16'h0000, 16'h0000, 0, 0, 1));
    tbl.push_back(mk(1, 2'd3, 16'h0abc, 0, 0, 0, 0, 16'h0000, 16'h0000, 0, 0, 1));
    tbl.push_back(mk(0, 2'd1, 16'h0000, 0, 0, 0, 1, 16'h0000, 16'h0077, 0, 0, 1));

    // reset state, with PcEn requesting the bus while nReset is low
    pcen = 1'b1; tb_drv = 1'b1;
    #12;
    check("rst pc", pc, 16'h0000);
    check("rst bus hiz", sysbus, PAT);
    check("rst empty", 16'(empty), 16'd1);
    check("rst full", 16'(full), 16'd0);
    check("rst err", 16'(stkerr), 16'd0);
    @(negedge clk);
    nreset = 1'b1;

    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i]);
      exp_q.push_back(tbl[i]);
      @(posedge clk);
      #1;
      e = exp_q.pop_front();
      compare($sformatf("vec%0d", i), e);
      @(negedge clk);
    end

    // asynchronous reset in the middle of a push: 3 entries, PC=0x1234
    v = mk(1, 2'd2, 16'h1234, 1, 0, 1, 0, 16'h1234, 16'h1234, 0, 0, 1);
    drive(v); @(posedge clk); #1; @(negedge clk);
    v = mk(0, 2'd0, 16'h0abc, 1, 0, 1, 0, 16'h1234, 16'h1234, 0, 0, 1);
    drive(v); @(posedge clk); #1;
    check("pre-rst pc", pc, 16'h1234);
    @(negedge clk);
    lrwe = 1'b1; alu = 16'h5555; pcen = 1'b1; tb_drv = 1'b1;
    #1 nreset = 1'b0;
    #1;
    check("midrst pc", pc, 16'h0000);
    check("midrst empty", 16'(empty), 16'd1);
    check("midrst err", 16'(stkerr), 16'd0);
    check("midrst full", 16'(full), 16'd0);
    check("midrst bus hiz", sysbus, PAT);
    @(negedge clk);
    nreset = 1'b1;
    v = mk(1, 2'd0, 16'h0000, 0, 0, 1, 0, 16'h0001, 16'h0001, 0, 1, 0);
    drive(v);
    exp_q.push_back(v);
    @(posedge clk); #1;
    e = exp_q.pop_front();
    compare("post-rst", e);
    @(negedge clk);
    v = mk(0, 2'd0, 16'h0000, 0, 0, 0, 1, 16'h0001, 16'h0000, 0, 1, 0);
    drive(v);
    exp_q.push_back(v);
    @(posedge clk); #1;
    e = exp_q.pop_front();
    compare("post-rst top", e);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
